reg_wb_arbiter: RTL
===================

// Module: reg_wb_arbiter
// PURPOSE
//   Writeback controller for the 8x16 LC-3 register file's single write port.
//   Arbitrates round-robin between two writeback sources: ALU and memory load.
//   Drives the regfile write port (we/DR/data) through one register stage.
//   Keeps a per-register pending-write scoreboard so decode can stall on RAW
//   hazards, and updates the NZP condition codes on every write.
// PARAMETERS
//   DATA_W      16  regfile data width
//   REG_ADDR_W  3   register index width
//   NUM_REGS    8   number of architectural registers (2**REG_ADDR_W)
//   CNT_W       2   per-register pending counter width; saturates at 2**CNT_W-1
// PORTS
//   clk          in   1           system clock; all state on posedge
//   rst_n        in   1           asynchronous reset, active-low
//   issue_valid  in   1           decode reserves a destination register
//   issue_dr     in   REG_ADDR_W  register being reserved
//   issue_ready  out  1           reservation accepted this cycle
//   sr1, sr2     in   REG_ADDR_W  decode source registers to check
//   sr1_busy     out  1           sr1 has a pending write (combinational)
//   sr2_busy     out  1           sr2 has a pending write (combinational)
//   alu_valid    in   1           ALU writeback request
//   alu_dr       in   REG_ADDR_W  ALU destination register
//   alu_data     in   DATA_W      ALU result
//   alu_ready    out  1           ALU request granted
//   mem_valid    in   1           load writeback request
//   mem_dr       in   REG_ADDR_W  load destination register
//   mem_data     in   DATA_W      load data
//   mem_ready    out  1           load request granted
//   rf_we        out  1           regfile write enable, registered
//   rf_dr        out  REG_ADDR_W  regfile destination, registered
//   rf_data      out  DATA_W      regfile write data, registered
//   cc_nzp       out  3           condition codes {N,Z,P}, registered
//   err_unres    out  1           sticky: a write hit a register with count 0
// BEHAVIOUR
//   Reset (async, rst_n=0): rf_we=0, rf_dr=0, rf_data=0, cc_nzp=3'b010,
//     err_unres=0, all pending counters=0, last_grant=MEM (ALU wins first tie).
//   Arbitration (combinational, single state bit last_grant):
//     only one source valid -> that source is granted;
//     both valid -> grant the source not in last_grant;
//     none valid -> no grant, last_grant holds.
//     ready may depend on valid.
//     A transfer is valid&&ready; on a transfer, last_grant updates to the winner.
//   Output stage: a transfer in cycle N gives rf_we=1, rf_dr, rf_data in cycle N+1.
//     The regfile writes on the edge ending N+1.
//     With no transfer, rf_we=0 and rf_dr/rf_data hold.
//     Back-to-back transfers give one write per cycle, with no bubbles.
//   Scoreboard: one CNT_W-bit counter per register.
//     +1 on an accepted issue (issue_valid&&issue_ready) to that register.
//     -1 in any cycle with rf_we=1 to rf_dr.
//     Increment and decrement of the same register in one cycle: no change.
//     The decrement happens on the same edge as the regfile write.
//     So busy drops in the cycle the new value is readable.
//   issue_ready = (count[issue_dr] != max). Decided on the current count only.
//     A decrement in the same cycle does not free the slot.
//   srX_busy = (count[srX] != 0).
//   Underflow: rf_we to a register whose count is 0 leaves the count at 0
//     and sets err_unres. err_unres clears only on reset.
//   cc_nzp is updated on every edge with rf_we=1, computed from rf_data:
//     N = rf_data[DATA_W-1]; Z = (rf_data==0); P = otherwise.
//     Exactly one bit is set.
//   Reset mid-operation: in-flight writes and reservations are dropped.
//     Requesters must re-present them.
// STRUCTURE
//   Shared header lc3_defs.vh holds DATA_W, REG_ADDR_W, NUM_REGS, the CC_N/CC_Z/CC_P
//     encodings and the source ids SRC_ALU/SRC_MEM.
//   Sub-module reg_scoreboard holds the counter array, the issue_ready and
//     busy logic, and the underflow flag.
//   Arbiter, output stage and CC logic stay in the top module.
// TESTING
//   1 Reset: assert rst_n=0 with no clock.
//     -> all outputs at reset values; cc_nzp=010; sr1_busy=0.
//   2 Single write: issue R3; then alu_valid, alu_dr=3, alu_data=16'h8001.
//     -> alu_ready=1; next cycle rf_we=1, rf_dr=3.
//     -> following cycle cc_nzp=100, sr1_busy(sr1=3)=0.
//   3 Tie: alu and mem valid for 4 cycles (ALU to R1, MEM to R2).
//     -> grants go ALU, MEM, ALU, MEM; rf_we high 4 cycles in a row.
//   4 Saturation: issue R5 three times.
//     -> the 4th issue sees issue_ready=0.
//     -> after one write to R5, issue_ready=1 and count=2.
//   5 Same-cycle issue and release on R2 with count=1 -> count stays 1, busy=1.
//   6 Unreserved write to R7 with data 0 -> err_unres=1 sticky, cc_nzp=010.
//     Then pulse rst_n low mid-stream -> counters and err_unres clear.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared LC-3 writeback definitions: datapath widths, condition-code encodings, source ids.
// No logic; constants and types only.
// Imported by the writeback arbiter and its scoreboard.
package reg_wb_arbiter_pkg;

  localparam int LC3_DATA_W     = 16;
  localparam int LC3_REG_ADDR_W = 3;
  localparam int LC3_NUM_REGS   = 8;
  localparam int LC3_CNT_W      = 2;

  // One-hot {N,Z,P}; exactly one bit is ever set.
  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  // Writeback sources competing for the single regfile write port.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with issue admission, source busy flags and underflow flag.
// issue_ready/busy are combinational from current counts; counters update on the next edge.
// Issue is refused while the destination counter is saturated; a release never frees it early.
module reg_scoreboard
  import reg_wb_arbiter_pkg::*;
#(
  parameter int REG_ADDR_W = LC3_REG_ADDR_W,
  parameter int NUM_REGS   = LC3_NUM_REGS,
  parameter int CNT_W      = LC3_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_dr_i,
  output logic                  issue_ready_o,
  input  logic                  rel_vld_i,
  input  logic [REG_ADDR_W-1:0] rel_dr_i,
  input  logic [REG_ADDR_W-1:0] sr1_i,
  input  logic [REG_ADDR_W-1:0] sr2_i,
  output logic                  sr1_busy_o,
  output logic                  sr2_busy_o,
  output logic                  err_unres_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             err_q, err_d;
  logic             issue_acc;

  // Admission and hazard flags look only at the counts as they stand this cycle.
  always_comb begin
    issue_ready_o = (cnt_q[issue_dr_i] != CNT_MAX);
    sr1_busy_o    = (cnt_q[sr1_i] != '0);
    sr2_busy_o    = (cnt_q[sr2_i] != '0);
    issue_acc     = issue_valid_i && issue_ready_o;
  end

  // Count reservations up and regfile writes down; simultaneous inc/dec cancel, zero floors.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | (rel_vld_i && (cnt_q[rel_dr_i] == '0));
    for (int i = 0; i < NUM_REGS; i++) begin
      if (issue_acc && (issue_dr_i == REG_ADDR_W'(i)) &&
          !(rel_vld_i && (rel_dr_i == REG_ADDR_W'(i)))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (rel_vld_i && (rel_dr_i == REG_ADDR_W'(i)) &&
                   !(issue_acc && (issue_dr_i == REG_ADDR_W'(i))) &&
                   (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Counter array and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_unres_o = err_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin ALU/load writeback arbiter driving the LC-3 regfile port, plus NZP and scoreboard.
// Grant is combinational; regfile write appears one cycle after the transfer; NZP one cycle later.
// A source not granted sees ready low and holds its request; back-to-back grants write every cycle.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = LC3_DATA_W,
  parameter int REG_ADDR_W = LC3_REG_ADDR_W,
  parameter int NUM_REGS   = LC3_NUM_REGS,
  parameter int CNT_W      = LC3_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_dr,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] sr1,
  input  logic [REG_ADDR_W-1:0] sr2,
  output logic                  sr1_busy,
  output logic                  sr2_busy,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_dr,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_dr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_dr,
  output logic [DATA_W-1:0]     rf_data,
  output logic [2:0]            cc_nzp,
  output logic                  err_unres
);

  src_e                  last_grant_q, last_grant_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_dr_q, rf_dr_d;
  logic [DATA_W-1:0]     rf_data_q, rf_data_d;
  logic [2:0]            cc_q, cc_d;

  // Grant the lone requester, or on a tie the source that did not win last time.
  always_comb begin
    alu_ready    = alu_valid && (!mem_valid || (last_grant_q == SRC_MEM));
    mem_ready    = mem_valid && (!alu_valid || (last_grant_q == SRC_ALU));
    last_grant_d = last_grant_q;
    rf_we_d      = alu_ready || mem_ready;
    rf_dr_d      = rf_dr_q;
    rf_data_d    = rf_data_q;
    if (alu_ready) begin
      last_grant_d = SRC_ALU;
      rf_dr_d      = alu_dr;
      rf_data_d    = alu_data;
    end else if (mem_ready) begin
      last_grant_d = SRC_MEM;
      rf_dr_d      = mem_dr;
      rf_data_d    = mem_data;
    end
  end

  // Condition codes follow the value being written to the regfile this cycle.
  always_comb begin
    cc_d = cc_q;
    if (rf_we_q) begin
      if (rf_data_q[DATA_W-1])   cc_d = CC_N;
      else if (rf_data_q == '0)  cc_d = CC_Z;
      else                       cc_d = CC_P;
    end
  end

  // Output register stage, round-robin pointer and condition codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= SRC_MEM;
      rf_we_q      <= 1'b0;
      rf_dr_q      <= '0;
      rf_data_q    <= '0;
      cc_q         <= CC_Z;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_dr_q      <= rf_dr_d;
      rf_data_q    <= rf_data_d;
      cc_q         <= cc_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_dr   = rf_dr_q;
  assign rf_data = rf_data_q;
  assign cc_nzp  = cc_q;

  // Release a reservation on the same edge the regfile commits the write.
  reg_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_REGS   (NUM_REGS),
    .CNT_W      (CNT_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_dr_i    (issue_dr),
    .issue_ready_o (issue_ready),
    .rel_vld_i     (rf_we_q),
    .rel_dr_i      (rf_dr_q),
    .sr1_i         (sr1),
    .sr2_i         (sr2),
    .sr1_busy_o    (sr1_busy),
    .sr2_busy_o    (sr2_busy),
    .err_unres_o   (err_unres)
  );

endmodule
